// File: rtl/mc1_pkg.sv
// Shared types and constants for the MC1 truth-table sweep controller.
// No logic; no latency.
// No flow control.
package mc1_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Default number of cycles abcd is held before f is sampled
    localparam int SETTLE_DEF = 1;

    // Number of input vectors in one sweep (all combinations of A,B,C,D)
    localparam int NUM_VEC = 16;

endpackage

// File: rtl/mc1_sweep_ctrl.sv
// Sweeps abcd through 0..15 on an external MC1 block and captures F into a truth table.
// Latency: 16*(SETTLE+1) cycles from accepted start to the done pulse.
// start is ignored while busy or done; abort cancels a sweep in progress.
module mc1_sweep_ctrl
    import mc1_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_f,
    output logic [3:0]  o_abcd,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_truth_table,
    output logic [4:0]  o_ones_count
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [3:0]  r_abcd;
    logic [15:0] r_shadow;
    logic [4:0]  r_shadow_cnt;
    logic [15:0] r_truth_table;
    logic [4:0]  r_ones_count;

    state_t      w_state_nxt;
    logic        w_busy;
    logic        w_done;
    logic [15:0] w_shadow_nxt;
    logic [4:0]  w_shadow_cnt_nxt;

    // Shadow table and count as they will be after the current sample is folded in
    always_comb begin
        w_shadow_nxt     = r_shadow | (16'(i_f) << r_idx);
        w_shadow_cnt_nxt = r_shadow_cnt + {4'd0, i_f};
    end

    // Next-state decode and state-derived outputs; abort beats start and any progress
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_busy = 1'b1;
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus sweep datapath; results commit only on the edge entering DONE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= 4'd0;
            r_cnt         <= 4'd0;
            r_abcd        <= 4'd0;
            r_shadow      <= 16'd0;
            r_shadow_cnt  <= 5'd0;
            r_truth_table <= 16'd0;
            r_ones_count  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_WAIT) begin
                        r_idx        <= 4'd0;
                        r_abcd       <= 4'd0;
                        r_cnt        <= SETTLE_L;
                        r_shadow     <= 16'd0;
                        r_shadow_cnt <= 5'd0;
                    end
                end
                ST_WAIT: begin
                    if (w_state_nxt == ST_IDLE) begin
                        r_idx  <= 4'd0;
                        r_cnt  <= 4'd0;
                        r_abcd <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (w_state_nxt == ST_IDLE) begin
                        r_idx  <= 4'd0;
                        r_cnt  <= 4'd0;
                        r_abcd <= 4'd0;
                    end else begin
                        r_shadow     <= w_shadow_nxt;
                        r_shadow_cnt <= w_shadow_cnt_nxt;
                        if (w_state_nxt == ST_DONE) begin
                            r_truth_table <= w_shadow_nxt;
                            r_ones_count  <= w_shadow_cnt_nxt;
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_abcd <= r_idx + 4'd1;
                            r_cnt  <= SETTLE_L;
                        end
                    end
                end
                ST_DONE: begin
                    r_idx  <= 4'd0;
                    r_abcd <= 4'd0;
                end
                default: begin
                    r_idx  <= 4'd0;
                    r_abcd <= 4'd0;
                end
            endcase
        end
    end

    assign o_abcd        = r_abcd;
    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_truth_table = r_truth_table;
    assign o_ones_count  = r_ones_count;

endmodule

// File: tb/tb_mc1_sweep_ctrl.sv
// Bench for mc1_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) each driving a modelled MC1 function.
// Expected timing and results come from sweep arithmetic: vector k/(SETTLE+1), done at 16*(SETTLE+1).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_mc1_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a [2];
    logic        abort_a [2];
    logic        f_a     [2];
    logic [3:0]  abcd_a  [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic [15:0] tt_a    [2];
    logic [4:0]  ones_a  [2];

    int          mode_a  [2];
    logic [15:0] tbl_a   [2];
    logic [15:0] prev_tt [2];
    int          prev_ones [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc1_sweep_ctrl #(.SETTLE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a[0]), .i_abort(abort_a[0]),
        .i_f(f_a[0]), .o_abcd(abcd_a[0]), .o_busy(busy_a[0]), .o_done(done_a[0]),
        .o_truth_table(tt_a[0]), .o_ones_count(ones_a[0])
    );

    mc1_sweep_ctrl #(.SETTLE(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a[1]), .i_abort(abort_a[1]),
        .i_f(f_a[1]), .o_abcd(abcd_a[1]), .o_busy(busy_a[1]), .o_done(done_a[1]),
        .o_truth_table(tt_a[1]), .o_ones_count(ones_a[1])
    );

    // MC1 function model: 0 const0, 1 const1, 2 F=A, 3 parity, 4 lookup table
    function automatic logic fval(input int mode, input logic [3:0] v, input logic [15:0] tbl);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return v[3];
            3:       return ^v;
            default: return tbl[v];
        endcase
    endfunction

    always_comb f_a[0] = fval(mode_a[0], abcd_a[0], tbl_a[0]);
    always_comb f_a[1] = fval(mode_a[1], abcd_a[1], tbl_a[1]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status(input int d);
        return {5'd0, busy_a[d], done_a[d], abcd_a[d], ones_a[d], tt_a[d]};
    endfunction

    function automatic logic [31:0] mk(input logic b, input logic dn, input logic [3:0] v,
                                       input logic [4:0] o, input logic [15:0] t);
        return {5'd0, b, dn, v, o, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sweep on instance d; abort_at >= 0 aborts after edge abort_at
    task automatic run_sweep(input int d, input int mode, input logic [15:0] tbl,
                             input logic [15:0] exp_tt, input int exp_ones,
                             input bit mid_start, input int abort_at, input bit abort_in_done);
        int s;
        int n;
        int seen;
        s = (d == 0) ? 1 : 3;
        n = 16 * (s + 1);
        mode_a[d] = mode;
        tbl_a[d]  = tbl;
        start_a[d] = 1'b1;
        step();
        start_a[d] = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk("sweep_cycle", status(d),
                mk(1'b1, 1'b0, 4'(k / (s + 1)), 5'(prev_ones[d]), prev_tt[d]));
            if (k == abort_at) begin
                abort_a[d] = 1'b1;
                step();
                abort_a[d] = 1'b0;
                chk("after_abort", status(d), mk(1'b0, 1'b0, 4'd0, 5'(prev_ones[d]), prev_tt[d]));
                seen = 0;
                for (int j = 0; j < n; j++) begin
                    step();
                    if (done_a[d] || busy_a[d]) seen++;
                end
                chk("no_done_after_abort", 32'(seen), 32'd0);
                return;
            end
            if (mid_start && k == n / 2) start_a[d] = 1'b1;
            step();
            start_a[d] = 1'b0;
        end
        chk("done_cycle", status(d), mk(1'b0, 1'b1, 4'd15, 5'(exp_ones), exp_tt));
        prev_tt[d]   = exp_tt;
        prev_ones[d] = exp_ones;
        if (abort_in_done) abort_a[d] = 1'b1;
        step();
        abort_a[d] = 1'b0;
        chk("after_done", status(d), mk(1'b0, 1'b0, 4'd0, 5'(exp_ones), exp_tt));
    endtask

    typedef struct {
        int          d;
        int          mode;
        logic [15:0] exp_tt;
        int          exp_ones;
        bit          mid_start;
        bit          abort_in_done;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [15:0] rtt;
        int          rmode;
        int          rd;
        int          rab;
        vecs[0] = '{0, 0, 16'h0000, 0,  1'b0, 1'b0};
        vecs[1] = '{0, 2, 16'hFF00, 8,  1'b0, 1'b1};
        vecs[2] = '{1, 3, 16'h6996, 8,  1'b1, 1'b0};
        vecs[3] = '{0, 3, 16'h6996, 8,  1'b1, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_a[d] = 1'b0; abort_a[d] = 1'b0; mode_a[d] = 0; tbl_a[d] = 16'h0;
            prev_tt[d] = 16'h0; prev_ones[d] = 0;
        end
        step();
        step();
        chk("reset_dut1", status(0), 32'd0);
        chk("reset_dut3", status(1), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_sweep(vecs[i].d, vecs[i].mode, 16'h0, vecs[i].exp_tt, vecs[i].exp_ones,
                      vecs[i].mid_start, -1, vecs[i].abort_in_done);
        end

        // Abort at vector 7 keeps the old 16'h6996, then a full F=1 sweep
        run_sweep(1, 1, 16'h0, 16'hFFFF, 16, 1'b0, 7 * 4, 1'b0);
        chk("abort_keeps_tt", {11'd0, ones_a[1], tt_a[1]}, {11'd0, 5'd8, 16'h6996});
        run_sweep(1, 1, 16'h0, 16'hFFFF, 16, 1'b0, -1, 1'b0);

        // Reset at vector 9 on the SETTLE=1 instance
        mode_a[0] = 1;
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        for (int k = 0; k < 9 * 2; k++) step();
        chk("at_vector9", 32'(abcd_a[0]), 32'd9);
        rst_n = 1'b0;
        start_a[0] = 1'b1;
        abort_a[0] = 1'b1;
        step();
        chk("midsweep_reset_dut1", status(0), 32'd0);
        chk("midsweep_reset_dut3", status(1), 32'd0);
        rst_n = 1'b1;
        prev_tt[0] = 16'h0; prev_ones[0] = 0;
        prev_tt[1] = 16'h0; prev_ones[1] = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("start_abort_idle", {30'd0, busy_a[0], done_a[0]}, 32'd0);
        end
        start_a[0] = 1'b0;
        abort_a[0] = 1'b0;
        step();

        // Randomised sweeps against the behavioural model
        for (int r = 0; r < 8; r++) begin
            rd    = int'($urandom_range(0, 1));
            rmode = int'($urandom_range(0, 4));
            tbl_a[rd] = 16'($urandom);
            rtt = 16'h0;
            for (int i = 0; i < 16; i++) rtt[i] = fval(rmode, 4'(i), tbl_a[rd]);
            rab = ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(0, 16 * ((rd == 0) ? 2 : 4) - 1)) : -1;
            run_sweep(rd, rmode, tbl_a[rd], rtt, $countones(rtt), 1'(r % 2), rab, 1'(r % 3 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
